// File: rtl/gaplus_pkg.sv
// gaplus_pkg
//   Shared types and constants for the character ROM arbiter and its tag pipe.
//   owner_t : which fetch engine owns a ROM read (sprite or background)
//   rdtag_t : {valid, owner} travelling alongside an outstanding ROM read
//   ROM_LAT : read latency of the ROM controller, shared with that block
package gaplus_pkg;

    typedef enum logic {
        OWN_SP = 1'b0,
        OWN_BG = 1'b1
    } owner_t;

    localparam int GAPLUS_AW      = 15;
    localparam int GAPLUS_DW      = 16;
    localparam int ROM_LAT        = 2;
    localparam int STARVE_MAX_DEF = 6;
    localparam int STARVE_W       = 3;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rdtag_t;

endpackage

// File: rtl/gaplus_rdtag_pipe.sv
// gaplus_rdtag_pipe
//   LAT-deep shift register of read tags. A tag entering alongside ROM_RD
//   leaves exactly when the matching ROM_D word is on the bus.
//   Ports:
//     VCLKx4  : clock
//     RESET   : synchronous active-high reset, discards every in-flight tag
//     tag_in  : tag of the read issued this cycle
//     tag_out : tag belonging to the ROM_D word present this cycle
module gaplus_rdtag_pipe
    import gaplus_pkg::*;
#(
    parameter int LAT = ROM_LAT
) (
    input  logic   VCLKx4,
    input  logic   RESET,
    input  rdtag_t tag_in,
    output rdtag_t tag_out
);

    rdtag_t stage [LAT];

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            // NOTE: every stage is reset on purpose; a surviving valid bit
            // would emit a VALID for a read that was killed by reset.
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make this a true shift register;
            // blocking ones would collapse all stages into one cycle.
            stage[0] <= tag_in;
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[LAT-1];

endmodule

// File: rtl/gaplus_chrom_arbiter.sv
// gaplus_chrom_arbiter
//   Shares the single character ROM read port between the sprite renderer (SP)
//   and the background tile fetcher (BG). One read per clock at most; each
//   returned word is routed to the requester that issued it, LAT+2 cycles
//   after its ACK.
//   Ports:
//     VCLKx4                   : 4x video clock
//     RESET                    : synchronous active-high reset
//     HB                       : horizontal blank, sprite priority window
//     SP_REQ/SP_A/SP_ACK       : sprite request, address, grant pulse
//     SP_D/SP_VALID            : sprite read data and its strobe
//     BG_REQ/BG_A/BG_ACK       : background request, address, grant pulse
//     BG_D/BG_VALID            : background read data and its strobe
//     ROM_RD/ROM_A/ROM_D       : ROM controller read strobe, address, data
module gaplus_chrom_arbiter
    import gaplus_pkg::*;
#(
    parameter int AW         = GAPLUS_AW,
    parameter int DW         = GAPLUS_DW,
    parameter int LAT        = ROM_LAT,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          VCLKx4,
    input  logic          RESET,
    input  logic          HB,
    input  logic          SP_REQ,
    input  logic [AW-1:0] SP_A,
    output logic          SP_ACK,
    output logic [DW-1:0] SP_D,
    output logic          SP_VALID,
    input  logic          BG_REQ,
    input  logic [AW-1:0] BG_A,
    output logic          BG_ACK,
    output logic [DW-1:0] BG_D,
    output logic          BG_VALID,
    output logic          ROM_RD,
    output logic [AW-1:0] ROM_A,
    input  logic [DW-1:0] ROM_D
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    owner_t              rr_ptr;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic                grant_sp;
    logic                grant_bg;
    logic                rom_rd_q;
    owner_t              owner_q;
    rdtag_t              issue_tag;
    rdtag_t              ret_tag;

    // Arbitration: ACKs are combinational from REQ and the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path through the if/else tree can infer a latch.
        grant_sp   = 1'b0;
        grant_bg   = 1'b0;
        starve_nxt = starve_cnt;
        if (!RESET) begin
            if (SP_REQ && !BG_REQ) begin
                grant_sp = 1'b1;
            end else if (!SP_REQ && BG_REQ) begin
                grant_bg = 1'b1;
            end else if (SP_REQ && BG_REQ) begin
                if (HB) begin
                    // Sprite priority during blank, bounded by the starve limit;
                    // the increment stops at the limit, so the count saturates.
                    if (starve_cnt < STARVE_LIM) begin
                        grant_sp   = 1'b1;
                        starve_nxt = starve_cnt + 1'b1;
                    end else begin
                        grant_bg = 1'b1;
                    end
                end else if (rr_ptr == OWN_SP) begin
                    grant_bg = 1'b1;
                end else begin
                    grant_sp = 1'b1;
                end
            end
        end
        if (!BG_REQ || grant_bg) starve_nxt = '0;
    end

    assign SP_ACK = grant_sp;
    assign BG_ACK = grant_bg;

    // Issue stage: registered strobe, address and owner one cycle after grant.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            rom_rd_q   <= 1'b0;
            ROM_A      <= '0;
            owner_q    <= OWN_SP;
            rr_ptr     <= OWN_SP;
            starve_cnt <= '0;
        end else begin
            rom_rd_q   <= grant_sp | grant_bg;
            starve_cnt <= starve_nxt;
            if (grant_sp) begin
                ROM_A   <= SP_A;
                owner_q <= OWN_SP;
                rr_ptr  <= OWN_SP;
            end else if (grant_bg) begin
                ROM_A   <= BG_A;
                owner_q <= OWN_BG;
                rr_ptr  <= OWN_BG;
            end
        end
    end

    // A grant taken just before reset must not reach the ROM controller.
    assign ROM_RD = rom_rd_q & ~RESET;

    assign issue_tag.valid = ROM_RD;
    assign issue_tag.owner = owner_q;

    gaplus_rdtag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .VCLKx4  (VCLKx4),
        .RESET   (RESET),
        .tag_in  (issue_tag),
        .tag_out (ret_tag)
    );

    // Return stage: only the owner's data register loads; the other holds.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            SP_D     <= '0;
            BG_D     <= '0;
            SP_VALID <= 1'b0;
            BG_VALID <= 1'b0;
        end else begin
            SP_VALID <= ret_tag.valid && (ret_tag.owner == OWN_SP);
            BG_VALID <= ret_tag.valid && (ret_tag.owner == OWN_BG);
            if (ret_tag.valid && (ret_tag.owner == OWN_SP)) SP_D <= ROM_D;
            if (ret_tag.valid && (ret_tag.owner == OWN_BG)) BG_D <= ROM_D;
        end
    end

endmodule

// File: tb/tb_gaplus_chrom_arbiter.sv
// tb_gaplus_chrom_arbiter
//   Directed stimulus with a scoreboard: each expected grant pushes the
//   expected ROM issue and the expected data return into queues; two monitors
//   pop and compare whenever the DUT shows ROM_RD or a VALID pulse.
module tb_gaplus_chrom_arbiter;

    localparam int AW  = 15;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int SMX = 6;

    logic          VCLKx4 = 1'b0;
    logic          RESET  = 1'b1;
    logic          HB     = 1'b0;
    logic          SP_REQ = 1'b0;
    logic [AW-1:0] SP_A   = '0;
    logic          SP_ACK;
    logic [DW-1:0] SP_D;
    logic          SP_VALID;
    logic          BG_REQ = 1'b0;
    logic [AW-1:0] BG_A   = '0;
    logic          BG_ACK;
    logic [DW-1:0] BG_D;
    logic          BG_VALID;
    logic          ROM_RD;
    logic [AW-1:0] ROM_A;
    logic [DW-1:0] ROM_D;

    gaplus_chrom_arbiter #(
        .AW(AW), .DW(DW), .LAT(LAT), .STARVE_MAX(SMX)
    ) dut (
        .VCLKx4   (VCLKx4),
        .RESET    (RESET),
        .HB       (HB),
        .SP_REQ   (SP_REQ),
        .SP_A     (SP_A),
        .SP_ACK   (SP_ACK),
        .SP_D     (SP_D),
        .SP_VALID (SP_VALID),
        .BG_REQ   (BG_REQ),
        .BG_A     (BG_A),
        .BG_ACK   (BG_ACK),
        .BG_D     (BG_D),
        .BG_VALID (BG_VALID),
        .ROM_RD   (ROM_RD),
        .ROM_A    (ROM_A),
        .ROM_D    (ROM_D)
    );

    always #5 VCLKx4 = ~VCLKx4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge VCLKx4) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ROM contents: 0x1234 holds 0xBEEF, every other word is addr ^ 0xC3A5.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        if (a == 15'h1234) return 16'hBEEF;
        return {1'b0, a} ^ 16'hC3A5;
    endfunction

    // ROM controller model: data appears LAT cycles after ROM_RD.
    logic          rp_v [LAT];
    logic [AW-1:0] rp_a [LAT];
    always @(posedge VCLKx4) begin
        if (RESET) begin
            for (int i = 0; i < LAT; i++) rp_v[i] <= 1'b0;
        end else begin
            rp_v[0] <= ROM_RD;
            rp_a[0] <= ROM_A;
            for (int i = 1; i < LAT; i++) begin
                rp_v[i] <= rp_v[i-1];
                rp_a[i] <= rp_a[i-1];
            end
        end
    end
    assign ROM_D = rp_v[LAT-1] ? rom_word(rp_a[LAT-1]) : '0;

    typedef struct {
        int            at;
        logic          bg;
        logic [DW-1:0] data;
    } ret_t;

    typedef struct {
        int            at;
        logic [AW-1:0] addr;
    } iss_t;

    ret_t ret_q [$];
    iss_t iss_q [$];

    // ROM issue monitor.
    always @(negedge VCLKx4) begin
        if (ROM_RD) begin
            if (iss_q.size() == 0) begin
                check("unexpected_rom_rd", {17'd0, ROM_A}, 32'h7fff_ffff);
            end else begin
                iss_t e;
                e = iss_q.pop_front();
                check("rom_rd_cycle", cyc, e.at);
                check("rom_a", {17'd0, ROM_A}, {17'd0, e.addr});
            end
        end
    end

    // Data return monitor.
    always @(negedge VCLKx4) begin
        if (SP_VALID || BG_VALID) begin
            if (SP_VALID && BG_VALID) check("both_valid", 32'd1, 32'd0);
            if (ret_q.size() == 0) begin
                check("unexpected_valid", {30'd0, BG_VALID, SP_VALID}, 32'd0);
            end else begin
                ret_t e;
                e = ret_q.pop_front();
                check("ret_cycle", cyc, e.at);
                check("ret_owner_bg", {31'd0, BG_VALID}, {31'd0, e.bg});
                check("ret_data", {16'd0, (BG_VALID ? BG_D : SP_D)}, {16'd0, e.data});
            end
        end
    end

    // One arbitration cycle: drive, check ACKs at negedge, push expectations.
    task automatic step(input logic sreq, input logic [AW-1:0] sa,
                        input logic breq, input logic [AW-1:0] ba, input logic hb_i,
                        input logic exp_sp, input logic exp_bg, input logic track);
        iss_t is;
        ret_t rt;
        SP_REQ = sreq;
        SP_A   = sa;
        BG_REQ = breq;
        BG_A   = ba;
        HB     = hb_i;
        @(negedge VCLKx4);
        check("sp_ack", {31'd0, SP_ACK}, {31'd0, exp_sp});
        check("bg_ack", {31'd0, BG_ACK}, {31'd0, exp_bg});
        if (track && (exp_sp || exp_bg)) begin
            is.at   = cyc + 1;
            is.addr = exp_bg ? ba : sa;
            iss_q.push_back(is);
            rt.at   = cyc + LAT + 2;
            rt.bg   = exp_bg;
            rt.data = rom_word(is.addr);
            ret_q.push_back(rt);
        end
        @(posedge VCLKx4);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sp_ack"},   {31'd0, SP_ACK},   32'd0);
        check({tag, "_bg_ack"},   {31'd0, BG_ACK},   32'd0);
        check({tag, "_sp_valid"}, {31'd0, SP_VALID}, 32'd0);
        check({tag, "_bg_valid"}, {31'd0, BG_VALID}, 32'd0);
        check({tag, "_rom_rd"},   {31'd0, ROM_RD},   32'd0);
        check({tag, "_rom_a"},    {17'd0, ROM_A},    32'd0);
        check({tag, "_sp_d"},     {16'd0, SP_D},     32'd0);
        check({tag, "_bg_d"},     {16'd0, BG_D},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        RESET = 1'b1;
        repeat (3) @(posedge VCLKx4);
        #1;
        RESET = 1'b0;
        @(negedge VCLKx4);
        check_all_zero("reset");
        @(posedge VCLKx4);
        #1;

        // 1: single SP read of 0x1234 -> 0xBEEF four cycles after ACK.
        step(1'b1, 15'h1234, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // 2: round robin outside blank, pointer at SP -> BG, SP, BG, SP.
        for (int i = 0; i < 4; i++)
            step(1'b1, 15'h0100, 1'b1, 15'h0200, 1'b0, (i % 2) == 1, (i % 2) == 0, 1'b1);
        idle(6);

        // 3: blank priority, SP six times then a forced BG, then SP again.
        for (int i = 0; i < 8; i++)
            step(1'b1, 15'h0400 + 15'(i), 1'b1, 15'h0500, 1'b1, i != 6, i == 6, 1'b1);
        idle(6);

        // 4: ten back-to-back SP reads of addresses 0..9.
        for (int i = 0; i < 10; i++)
            step(1'b1, 15'(i), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // 6: BG raised then withdrawn in blank; the starve count must restart,
        //    so a fresh contention run again gives six SP grants before BG.
        step(1'b1, 15'h0300, 1'b0, 15'h0555, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 15'h0301, 1'b1, 15'h0555, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 15'h0302, 1'b1, 15'h0555, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 15'h0303, 1'b0, 15'h0555, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            step(1'b1, 15'h0310 + 15'(i), 1'b1, 15'h0666, 1'b1, i != 6, i == 6, 1'b1);
        idle(6);

        // 5: reset one cycle after an SP grant; that read must never return.
        step(1'b1, 15'h0777, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        RESET  = 1'b1;
        SP_REQ = 1'b1;
        @(negedge VCLKx4);
        check("rst_cycle_rom_rd", {31'd0, ROM_RD}, 32'd0);
        check("rst_cycle_sp_ack", {31'd0, SP_ACK}, 32'd0);
        @(posedge VCLKx4);
        #1;
        RESET  = 1'b0;
        SP_REQ = 1'b0;
        @(negedge VCLKx4);
        check_all_zero("post_reset");
        @(posedge VCLKx4);
        #1;
        idle(8);

        check("ret_q_drained", ret_q.size(), 32'd0);
        check("iss_q_drained", iss_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gaplus_chrom_arbiter.md
Name: gaplus_chrom_arbiter

Overview:
- Shares the single sprite/BG character ROM read port (SDRAM-backed, fixed read latency) between two requesters.
- Requester SP is the sprite scanline renderer; requester BG is the background tile fetcher.
- Issues at most one read per clock and routes each returned word to the requester that issued it.
- Sits between both fetch engines and the ROM controller, clocked at the 4x video clock.

Parameters:
AW, 15, ROM word address width
DW, 16, ROM data width
LAT, 2, cycles from ROM_RD sampled high to ROM_D valid (1..7)
STARVE_MAX, 6, consecutive HB cycles BG may be refused before a forced BG grant

Ports:
VCLKx4  in  1  clock
RESET  in  1  synchronous, active-high reset
HB  in  1  horizontal blank; sprite priority window
SP_REQ  in  1  sprite read request, held until SP_ACK
SP_A  in  AW  sprite read address, stable while SP_REQ high
SP_ACK  out  1  one-cycle grant pulse to sprite
SP_D  out  DW  sprite read data
SP_VALID  out  1  one-cycle pulse, SP_D valid
BG_REQ  in  1  BG read request, held until BG_ACK
BG_A  in  AW  BG read address
BG_ACK  out  1  one-cycle grant pulse to BG
BG_D  out  DW  BG read data
BG_VALID  out  1  one-cycle pulse, BG_D valid
ROM_RD  out  1  read strobe to ROM controller
ROM_A  out  AW  ROM address
ROM_D  in  DW  ROM data, valid LAT cycles after ROM_RD

Behaviour:
- Clock and reset: one clock VCLKx4; reset is synchronous and active-high (RESET).
- Reset values:
  - SP_ACK, BG_ACK, SP_VALID, BG_VALID, ROM_RD = 0.
  - ROM_A, SP_D, BG_D = 0.
  - Round-robin pointer = SP. Starve counter = 0. Tag pipe cleared.
- Handshake:
  - ACK is combinational from REQ and the current arbiter state; at most one ACK per cycle.
  - A requester seeing ACK high at cycle t may change its address or drop REQ at t+1.
  - REQ dropped without ACK is legal; no read is issued.
- Issue timing:
  - Grant at t: ROM_RD=1 and ROM_A=granted address, registered, at t+1.
  - Tag {valid, owner} enters the tag pipe at t+1.
- Return timing:
  - ROM_D is sampled at t+1+LAT.
  - Owner's D register loads ROM_D and VALID pulses at t+2+LAT.
  - The other requester's D holds its value.
  - Fixed ACK-to-VALID latency of LAT+2; returns stay in order.
- Arbitration, evaluated each cycle:
  - Only one REQ high: grant it.
  - Both high, HB=1, starve counter < STARVE_MAX: grant SP; starve counter +1.
  - Both high, HB=1, starve counter == STARVE_MAX: grant BG; counter to 0.
  - Both high, HB=0: round-robin; grant the requester not in the pointer; pointer := granted.
  - Any BG grant, or any cycle with BG_REQ=0, clears the starve counter.
- Pointer updates on every grant, including single-requester grants.
- Throughput: back-to-back grants every cycle; no bubbles.
- Counter width: 3 bits; saturates at STARVE_MAX.
- HB edge: arbitration mode switches on the same cycle HB changes. Transactions already in flight are unaffected.
- Reset mid-operation: all in-flight tags are discarded and no VALID is emitted for them. Late ROM_D is ignored.
- ROM_RD is never asserted while RESET=1, or in the cycle after RESET deasserts with no request.

Decomposition:
- Package gaplus_pkg:
  - owner type (OWN_SP=0, OWN_BG=1).
  - Default AW/DW constants.
  - ROM_LAT constant shared with the ROM controller.
- Sub-module gaplus_rdtag_pipe: a LAT-deep shift register of {valid, owner}, cleared by RESET. The top-level instantiates it once.

Test Plan:
1. Reset, then SP_REQ=1 with SP_A=0x1234 alone, LAT=2 -> SP_ACK at t; ROM_RD with ROM_A=0x1234 at t+1; ROM_D=0xBEEF driven at t+3; SP_VALID with SP_D=0xBEEF at t+4; BG_VALID stays 0.
2. HB=0, both REQ held for 4 cycles, pointer=SP after reset -> grant order BG, SP, BG, SP. ROM_A alternates between BG_A and SP_A; VALIDs return in the same order at LAT+2.
3. HB=1, both REQ held for 8 cycles, STARVE_MAX=6 -> SP granted 6 times, BG granted on the 7th cycle, SP on the 8th.
4. Sequential addresses 0..9 from SP every cycle -> 10 consecutive ROM_RD cycles, 10 SP_VALID pulses with data in issue order, no gaps.
5. RESET asserted one cycle after an SP grant -> no SP_VALID ever appears for that grant; all outputs 0 the cycle after RESET is sampled.
6. BG_REQ raised then dropped before ACK while SP holds REQ in HB -> no BG_ACK, no ROM_RD for BG_A, starve counter returns to 0.
